// File: rtl/tcm_axis_capture.sv
// tcm_axis_capture: captures AXI-Stream beats into an on-chip TCM buffer.
//   Linear (length-limited) or circular (wrap-around) capture, optional stop on
//   tlast, abort, 1-cycle read-first readback port and registered status.
//
// Ports:
//   s_axis_aclk / s_axis_aresetn   clock, asynchronous active-low reset
//   s_axis_t*                      AXI-Stream slave (tready high only in CAPTURE)
//   ctrl_*                         arm/abort pulses; mode, stop and length sampled on arm
//   rd_en / rd_addr                readback request
//   rd_data / rd_valid             readback response, 1 cycle after rd_en
//   stat_*                         busy, done, wrapped, tlast_seen, count, wr_ptr
//   ts_first / ts_last             beat timestamps
//
// Optional feature macro: TCM_AXIS_CAPTURE_TIMESTAMP_EN
//   defined   : 32-bit free-running cycle counter feeds ts_first / ts_last
//   undefined : ts_first / ts_last tied to 0, no counter built
module tcm_axis_capture #(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_TCM_ADDR_WIDTH     = 8
) (
  input  logic                               s_axis_aclk,
  input  logic                               s_axis_aresetn,
  output logic                               s_axis_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic                               s_axis_tlast,
  input  logic                               s_axis_tvalid,
  input  logic                               ctrl_arm,
  input  logic                               ctrl_abort,
  input  logic                               ctrl_circular,
  input  logic                               ctrl_stop_on_tlast,
  input  logic [C_TCM_ADDR_WIDTH:0]          ctrl_length,
  input  logic                               rd_en,
  input  logic [C_TCM_ADDR_WIDTH-1:0]        rd_addr,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]    rd_data,
  output logic                               rd_valid,
  output logic                               stat_busy,
  output logic                               stat_done,
  output logic                               stat_wrapped,
  output logic                               stat_tlast_seen,
  output logic [C_TCM_ADDR_WIDTH:0]          stat_count,
  output logic [C_TCM_ADDR_WIDTH-1:0]        stat_wr_ptr,
  output logic [31:0]                        ts_first,
  output logic [31:0]                        ts_last
);

  localparam int unsigned DW    = C_S_AXIS_TDATA_WIDTH;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned AW    = C_TCM_ADDR_WIDTH;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            circ_q, circ_d;
  logic            stop_q, stop_d;
  logic [CW-1:0]   len_q, len_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wrapped_q, wrapped_d;
  logic            tlast_seen_q, tlast_seen_d;
  logic            tready_q, busy_q, done_q;
  logic [DW-1:0]   rd_data_q;
  logic            rd_valid_q;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            beat_c;
  logic            arm_go_c;
  logic [DW-1:0]   wdata_c;

  // tready_q is exactly (state_q == ST_CAPTURE), so this is the accepted-beat strobe
  assign beat_c   = s_axis_tvalid & tready_q;
  // abort wins over a simultaneous arm; arm during CAPTURE is ignored
  assign arm_go_c = ctrl_arm & ~ctrl_abort & (state_q != ST_CAPTURE);

  // Byte-masked write data: unqualified bytes are stored as zero
  always_comb begin
    wdata_c = '0;
    for (int i = 0; i < int'(SW); i++) begin
      wdata_c[i*8 +: 8] = s_axis_tstrb[i] ? s_axis_tdata[i*8 +: 8] : 8'h00;
    end
  end

  // Next-state and capture bookkeeping
  always_comb begin
    state_d      = state_q;
    circ_d       = circ_q;
    stop_d       = stop_q;
    len_d        = len_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    wrapped_d    = wrapped_q;
    tlast_seen_d = tlast_seen_q;

    if (beat_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (count_q != CW'(DEPTH)) begin
        count_d = count_q + CW'(1);
      end
      if (s_axis_tlast) begin
        tlast_seen_d = 1'b1;
      end
      if (circ_q && (wr_ptr_q == AW'(DEPTH - 1))) begin
        wrapped_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_go_c) begin
          state_d      = ST_CAPTURE;
          wr_ptr_d     = '0;
          count_d      = '0;
          wrapped_d    = 1'b0;
          tlast_seen_d = 1'b0;
          circ_d       = ctrl_circular;
          stop_d       = ctrl_stop_on_tlast;
          // 0 or anything beyond the buffer means "fill the buffer"
          len_d        = ((ctrl_length == '0) || (ctrl_length > CW'(DEPTH)))
                         ? CW'(DEPTH) : ctrl_length;
        end
      end
      ST_CAPTURE: begin
        if (ctrl_abort) begin
          state_d = ST_DONE;
        end else if (beat_c) begin
          if (stop_q && s_axis_tlast) begin
            state_d = ST_DONE;
          end
          if (!circ_q && ((count_q + CW'(1)) == len_q)) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered status
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q      <= ST_IDLE;
      circ_q       <= 1'b0;
      stop_q       <= 1'b0;
      len_q        <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      wrapped_q    <= 1'b0;
      tlast_seen_q <= 1'b0;
      tready_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      circ_q       <= circ_d;
      stop_q       <= stop_d;
      len_q        <= len_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      wrapped_q    <= wrapped_d;
      tlast_seen_q <= tlast_seen_d;
      tready_q     <= (state_d == ST_CAPTURE);
      busy_q       <= (state_d == ST_CAPTURE);
      done_q       <= (state_d == ST_DONE);
    end
  end

  // TCM write port (contents are not reset)
  always_ff @(posedge s_axis_aclk) begin
    if (beat_c) begin
      mem_q[wr_ptr_q] <= wdata_c;
    end
  end

  // Readback: read-first against a same-cycle write to the same word
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= mem_q[rd_addr];
      end
    end
  end

`ifdef TCM_AXIS_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt_q;
  logic [31:0] ts_first_q;
  logic [31:0] ts_last_q;

  // Free-running cycle counter; first beat is recognised by count still at 0
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      ts_cnt_q   <= '0;
      ts_first_q <= '0;
      ts_last_q  <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (arm_go_c) begin
        ts_first_q <= '0;
        ts_last_q  <= '0;
      end else if (beat_c) begin
        if (count_q == '0) begin
          ts_first_q <= ts_cnt_q;
        end
        ts_last_q <= ts_cnt_q;
      end
    end
  end

  assign ts_first = ts_first_q;
  assign ts_last  = ts_last_q;
`else
  assign ts_first = '0;
  assign ts_last  = '0;
`endif

  assign s_axis_tready   = tready_q;
  assign rd_data         = rd_data_q;
  assign rd_valid        = rd_valid_q;
  assign stat_busy       = busy_q;
  assign stat_done       = done_q;
  assign stat_wrapped    = wrapped_q;
  assign stat_tlast_seen = tlast_seen_q;
  assign stat_count      = count_q;
  assign stat_wr_ptr     = wr_ptr_q;

endmodule

// File: tb/tb_tcm_axis_capture.sv
// tb_tcm_axis_capture: directed self-checking bench for tcm_axis_capture
// (32-bit data, 16-word buffer).
module tb_tcm_axis_capture;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            tready;
  logic [DW-1:0]   tdata;
  logic [3:0]      tstrb;
  logic            tlast;
  logic            tvalid;
  logic            ctrl_arm;
  logic            ctrl_abort;
  logic            ctrl_circular;
  logic            ctrl_stop;
  logic [AW:0]     ctrl_length;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;
  logic            stat_busy;
  logic            stat_done;
  logic            stat_wrapped;
  logic            stat_tlast_seen;
  logic [AW:0]     stat_count;
  logic [AW-1:0]   stat_wr_ptr;
  logic [31:0]     ts_first;
  logic [31:0]     ts_last;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tcm_axis_capture #(
    .C_S_AXIS_TDATA_WIDTH (32),
    .C_TCM_ADDR_WIDTH     (4)
  ) dut (
    .s_axis_aclk        (clk),
    .s_axis_aresetn     (rst_n),
    .s_axis_tready      (tready),
    .s_axis_tdata       (tdata),
    .s_axis_tstrb       (tstrb),
    .s_axis_tlast       (tlast),
    .s_axis_tvalid      (tvalid),
    .ctrl_arm           (ctrl_arm),
    .ctrl_abort         (ctrl_abort),
    .ctrl_circular      (ctrl_circular),
    .ctrl_stop_on_tlast (ctrl_stop),
    .ctrl_length        (ctrl_length),
    .rd_en              (rd_en),
    .rd_addr            (rd_addr),
    .rd_data            (rd_data),
    .rd_valid           (rd_valid),
    .stat_busy          (stat_busy),
    .stat_done          (stat_done),
    .stat_wrapped       (stat_wrapped),
    .stat_tlast_seen    (stat_tlast_seen),
    .stat_count         (stat_count),
    .stat_wr_ptr        (stat_wr_ptr),
    .ts_first           (ts_first),
    .ts_last            (ts_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic circ, input logic stop, input logic [AW:0] len);
    ctrl_arm      = 1'b1;
    ctrl_circular = circ;
    ctrl_stop     = stop;
    ctrl_length   = len;
    tick();
    ctrl_arm = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    tvalid = 1'b1;
    tdata  = d;
    tstrb  = s;
    tlast  = l;
    tick();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk({tag, " valid"}, 32'(rd_valid), 32'd1);
    chk(tag, rd_data, exp);
  endtask

  task automatic abort_pulse();
    ctrl_abort = 1'b1;
    tick();
    ctrl_abort = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tdata = '0; tstrb = '0; tlast = 1'b0; tvalid = 1'b0;
    ctrl_arm = 1'b0; ctrl_abort = 1'b0; ctrl_circular = 1'b0; ctrl_stop = 1'b0;
    ctrl_length = '0; rd_en = 1'b0; rd_addr = '0;
    tick(); tick();

    // Reset state
    chk("rst tready",   32'(tready),       32'd0);
    chk("rst busy",     32'(stat_busy),    32'd0);
    chk("rst done",     32'(stat_done),    32'd0);
    chk("rst count",    32'(stat_count),   32'd0);
    chk("rst wr_ptr",   32'(stat_wr_ptr),  32'd0);
    chk("rst rd_valid", 32'(rd_valid),     32'd0);
    chk("rst rd_data",  rd_data,           32'd0);
    chk("rst ts_first", ts_first,          32'd0);
    rst_n = 1'b1;
    tick();

    // Linear capture, length 4, six beats offered back-to-back
    arm(1'b0, 1'b0, 5'd4);
    chk("lin tready up", 32'(tready),    32'd1);
    chk("lin busy",      32'(stat_busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tvalid = 1'b1;
      tdata  = 32'((i + 1) * 'h11);
      tstrb  = 4'hf;
      if (i == 4) chk("lin tready drop", 32'(tready), 32'd0);
      tick();
    end
    tvalid = 1'b0;
    chk("lin done",   32'(stat_done),       32'd1);
    chk("lin busy0",  32'(stat_busy),       32'd0);
    chk("lin count",  32'(stat_count),      32'd4);
    chk("lin wr_ptr", 32'(stat_wr_ptr),     32'd4);
    chk("lin tlast",  32'(stat_tlast_seen), 32'd0);
    rd("lin addr0", 4'd0, 32'h11);
    rd("lin addr1", 4'd1, 32'h22);
    rd("lin addr2", 4'd2, 32'h33);
    rd("lin addr3", 4'd3, 32'h44);

    // Circular capture, 20 beats into 16 words, length ignored, then abort
    arm(1'b1, 1'b0, 5'd3);
    for (int i = 0; i < 20; i++) begin
      tvalid = 1'b1;
      tdata  = 32'(i);
      tstrb  = 4'hf;
      tick();
    end
    tvalid = 1'b0;
    chk("circ busy",    32'(stat_busy),    32'd1);
    chk("circ wrapped", 32'(stat_wrapped), 32'd1);
    chk("circ count",   32'(stat_count),   32'd16);
    chk("circ wr_ptr",  32'(stat_wr_ptr),  32'd4);
    abort_pulse();
    chk("circ done",    32'(stat_done),    32'd1);
    chk("circ tready",  32'(tready),       32'd0);
    rd("circ addr0", 4'd0, 32'd16);
    rd("circ addr3", 4'd3, 32'd19);
    rd("circ addr4", 4'd4, 32'd4);

    // Stop on tlast with partial strobe on beat 2
    arm(1'b0, 1'b1, 5'd0);
    beat(32'h01020304, 4'hf, 1'b0);
    beat(32'hAABBCCDD, 4'b0101, 1'b0);
    chk("tl busy", 32'(stat_busy), 32'd1);
    beat(32'h55667788, 4'hf, 1'b1);
    chk("tl done",   32'(stat_done),       32'd1);
    chk("tl seen",   32'(stat_tlast_seen), 32'd1);
    chk("tl count",  32'(stat_count),      32'd3);
    chk("tl tready", 32'(tready),          32'd0);
    rd("tl strb addr1", 4'd1, 32'h00BB00DD);
    rd("tl addr2",      4'd2, 32'h55667788);

    // Arm and abort together from IDLE: nothing happens
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    ctrl_arm = 1'b1; ctrl_abort = 1'b1;
    tick();
    ctrl_arm = 1'b0; ctrl_abort = 1'b0;
    chk("armabort busy",   32'(stat_busy), 32'd0);
    chk("armabort done",   32'(stat_done), 32'd0);
    chk("armabort tready", 32'(tready),    32'd0);

    // Re-arm during capture ignored; beat in abort cycle still written
    arm(1'b0, 1'b0, 5'd10);
    beat(32'hA0, 4'hf, 1'b0);
    beat(32'hA1, 4'hf, 1'b0);
    ctrl_arm = 1'b1;
    tick();
    ctrl_arm = 1'b0;
    chk("rearm count",  32'(stat_count),  32'd2);
    chk("rearm wr_ptr", 32'(stat_wr_ptr), 32'd2);
    chk("rearm busy",   32'(stat_busy),   32'd1);
    beat(32'hA2, 4'hf, 1'b0);
    tvalid = 1'b1; tdata = 32'hDEAD; tstrb = 4'hf; ctrl_abort = 1'b1;
    tick();
    tvalid = 1'b0; ctrl_abort = 1'b0;
    chk("abortbeat done",  32'(stat_done),  32'd1);
    chk("abortbeat count", 32'(stat_count), 32'd4);
    rd("abortbeat addr3", 4'd3, 32'hDEAD);

    // Asynchronous reset mid-capture, then restart from address 0
    arm(1'b0, 1'b0, 5'd0);
    beat(32'h1111, 4'hf, 1'b0);
    beat(32'h2222, 4'hf, 1'b0);
    chk("pre-rst count", 32'(stat_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst tready",  32'(tready),      32'd0);
    chk("arst busy",    32'(stat_busy),   32'd0);
    chk("arst count",   32'(stat_count),  32'd0);
    chk("arst wr_ptr",  32'(stat_wr_ptr), 32'd0);
    chk("arst rd_data", rd_data,          32'd0);
    #2 rst_n = 1'b1;
    tick();
    arm(1'b0, 1'b0, 5'd0);
    beat(32'h77, 4'hf, 1'b0);
    chk("rearm2 wr_ptr", 32'(stat_wr_ptr), 32'd1);
    chk("rearm2 count",  32'(stat_count),  32'd1);
    rd("rearm2 addr0", 4'd0, 32'h77);
    abort_pulse();

    // Length beyond depth clamps to depth; read-first on same-cycle write
    arm(1'b0, 1'b0, 5'd20);
    for (int i = 0; i < 18; i++) begin
      tvalid = 1'b1;
      tdata  = 32'('h100 + i);
      tstrb  = 4'hf;
      if (i == 0) begin
        rd_en = 1'b1; rd_addr = 4'd0;
      end
      tick();
      rd_en = 1'b0;
      if (i == 0) chk("read-first addr0", rd_data, 32'h77);
    end
    tvalid = 1'b0;
    chk("clamp done",    32'(stat_done),    32'd1);
    chk("clamp count",   32'(stat_count),   32'd16);
    chk("clamp wr_ptr",  32'(stat_wr_ptr),  32'd0);
    chk("clamp wrapped", 32'(stat_wrapped), 32'd0);
    rd("clamp addr0",  4'd0,  32'h100);
    rd("clamp addr15", 4'd15, 32'h10F);

    // Timestamps: two beats three cycles apart
    arm(1'b0, 1'b0, 5'd0);
    chk("ts clr first", ts_first, 32'd0);
    chk("ts clr last",  ts_last,  32'd0);
    beat(32'h5, 4'hf, 1'b0);
    tick();
    tick();
    beat(32'h6, 4'hf, 1'b0);
    chk("ts count", 32'(stat_count), 32'd2);
`ifdef TCM_AXIS_CAPTURE_TIMESTAMP_EN
    chk("ts delta", ts_last - ts_first, 32'd3);
`else
    chk("ts first off", ts_first, 32'd0);
    chk("ts last off",  ts_last,  32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
